pixel_stream_source: RTL and testbench



---
 rtl/pixel_stream_source_if.sv | 32 +++
 rtl/pixel_stream_source.sv | 178 +++++++++++++++++
 tb/tb_pixel_stream_source.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_stream_source_if.sv
`default_nettype none
// ============================================================================
// pixel_stream_source_if : frame-memory read port plus raster pixel stream
// Revision: 1.0
// ============================================================================
interface pixel_stream_source_if #(
    parameter int ADDR_W = 19,
    parameter int PIX_W  = 12
) ();
    logic              iSTART;
    logic              iPATTERN;
    logic              oRD_EN;
    logic [ADDR_W-1:0] oRD_ADDR;
    logic [PIX_W-1:0]  iRD_DATA;
    logic [PIX_W-1:0]  oPIXEL;
    logic              oDVAL;
    logic              oSOF;
    logic              oEOL;
    logic              oEOF;
    logic              oBUSY;

    modport master (
        input  iSTART, iPATTERN, iRD_DATA,
        output oRD_EN, oRD_ADDR, oPIXEL, oDVAL, oSOF, oEOL, oEOF, oBUSY
    );

    modport slave (
        output iSTART, iPATTERN, iRD_DATA,
        input  oRD_EN, oRD_ADDR, oPIXEL, oDVAL, oSOF, oEOL, oEOF, oBUSY
    );
endinterface
`default_nettype wire

// File: rtl/pixel_stream_source.sv
`default_nettype none
// ============================================================================
// pixel_stream_source : raster frame reader with line blanking and latency-
// aligned valid/SOF/EOL/EOF. Optional test pattern: PIXEL_STREAM_SOURCE_PATTERN_EN
// Revision: 1.0
// ============================================================================
module pixel_stream_source #(
    parameter int WIDTH   = 640,
    parameter int HEIGHT  = 480,
    parameter int PIX_W   = 12,
    parameter int ADDR_W  = 19,
    parameter int H_BLANK = 16,
    parameter int RD_LAT  = 1
) (
    input  wire logic              iCLK,
    input  wire logic              iRST,
    pixel_stream_source_if.master  bus
);

    localparam int X_W = $clog2(WIDTH);
    localparam int Y_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int B_W = (H_BLANK > 1) ? $clog2(H_BLANK) : 1;
    localparam logic [X_W-1:0] X_LAST = X_W'(WIDTH - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(HEIGHT - 1);
    localparam logic [B_W-1:0] B_LAST = B_W'((H_BLANK > 0) ? H_BLANK - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_HBLANK = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [X_W-1:0]      x_q, x_d;
    logic [Y_W-1:0]      y_q, y_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [B_W-1:0]      blank_q, blank_d;

    // Delay line entry: {valid, sof, eol, eof}
    logic [3:0]          stage_q [RD_LAT];
    logic [3:0]          stage_in;

    logic                dval_q, sof_q, eol_q, eof_q;
    logic [PIX_W-1:0]    pix_q;
    logic [PIX_W-1:0]    pix_src;

    logic                rd_issue;
    logic                is_eol;
    logic                is_last_line;

    assign rd_issue     = (state_q == S_ACTIVE);
    assign is_eol       = (x_q == X_LAST);
    assign is_last_line = (y_q == Y_LAST);
    assign stage_in     = {rd_issue,
                           rd_issue & (x_q == '0) & (y_q == '0),
                           rd_issue & is_eol,
                           rd_issue & is_eol & is_last_line};

`ifdef PIXEL_STREAM_SOURCE_PATTERN_EN
    logic                pat_q, pat_d;
    logic [PIX_W-1:0]    pat_pipe_q [RD_LAT];
    logic [11:0]         pat_raw;

    assign pat_raw     = {6'(x_q), 6'(y_q)};
    assign pix_src     = pat_q ? pat_pipe_q[RD_LAT-1] : bus.iRD_DATA;
    assign bus.oRD_EN  = rd_issue & ~pat_q;

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            pat_q <= 1'b0;
            for (int i = 0; i < RD_LAT; i++) pat_pipe_q[i] <= '0;
        end else begin
            pat_q         <= pat_d;
            pat_pipe_q[0] <= PIX_W'(pat_raw);
            for (int i = 1; i < RD_LAT; i++) pat_pipe_q[i] <= pat_pipe_q[i-1];
        end
    end
`else
    logic unused_pattern;
    assign unused_pattern = bus.iPATTERN;
    assign pix_src        = bus.iRD_DATA;
    assign bus.oRD_EN     = rd_issue;
`endif

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        addr_d  = addr_q;
        blank_d = blank_q;
`ifdef PIXEL_STREAM_SOURCE_PATTERN_EN
        pat_d   = pat_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.iSTART) begin
                    state_d = S_ACTIVE;
`ifdef PIXEL_STREAM_SOURCE_PATTERN_EN
                    pat_d   = bus.iPATTERN;
`endif
                end
            end
            S_ACTIVE: begin
                addr_d = addr_q + 1'b1;
                if (is_eol) begin
                    x_d = '0;
                    if (is_last_line) begin
                        // Rewind so the next frame starts from address 0.
                        y_d     = '0;
                        addr_d  = '0;
                        state_d = S_DRAIN;
                    end else begin
                        y_d     = y_q + 1'b1;
                        blank_d = '0;
                        state_d = (H_BLANK == 0) ? S_ACTIVE : S_HBLANK;
                    end
                end else begin
                    x_d = x_q + 1'b1;
                end
            end
            S_HBLANK: begin
                if (blank_q == B_LAST) state_d = S_ACTIVE;
                else                   blank_d = blank_q + 1'b1;
            end
            S_DRAIN: begin
                if (eof_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            addr_q  <= '0;
            blank_q <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            addr_q  <= addr_d;
            blank_q <= blank_d;
        end
    end

    // Flags ride alongside the read so they line up with iRD_DATA.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            for (int i = 0; i < RD_LAT; i++) stage_q[i] <= '0;
            dval_q <= 1'b0;
            sof_q  <= 1'b0;
            eol_q  <= 1'b0;
            eof_q  <= 1'b0;
            pix_q  <= '0;
        end else begin
            stage_q[0] <= stage_in;
            for (int i = 1; i < RD_LAT; i++) stage_q[i] <= stage_q[i-1];
            dval_q <= stage_q[RD_LAT-1][3];
            sof_q  <= stage_q[RD_LAT-1][2];
            eol_q  <= stage_q[RD_LAT-1][1];
            eof_q  <= stage_q[RD_LAT-1][0];
            if (stage_q[RD_LAT-1][3]) pix_q <= pix_src;
        end
    end

    assign bus.oRD_ADDR = addr_q;
    assign bus.oPIXEL   = pix_q;
    assign bus.oDVAL    = dval_q;
    assign bus.oSOF     = sof_q;
    assign bus.oEOL     = eol_q;
    assign bus.oEOF     = eof_q;
    assign bus.oBUSY    = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_pixel_stream_source.sv
`default_nettype none
// ============================================================================
// tb_pixel_stream_source : directed frame scenarios on three parameter sets
// Revision: 1.0
// ============================================================================
module tb_pixel_stream_source;

    logic clk;
    logic rst_n;
    logic start;
    logic pattern;
    int   sel;
    int   n_checks;
    int   n_errors;

    int   exp_addr[$];
    int   exp_pix[$];

    pixel_stream_source_if #(.ADDR_W(19), .PIX_W(12)) if_a ();
    pixel_stream_source_if #(.ADDR_W(19), .PIX_W(12)) if_b ();
    pixel_stream_source_if #(.ADDR_W(19), .PIX_W(12)) if_c ();

    pixel_stream_source #(.WIDTH(4), .HEIGHT(3), .PIX_W(12), .ADDR_W(19),
                          .H_BLANK(2), .RD_LAT(1))
        u_dut_a (.iCLK(clk), .iRST(rst_n), .bus(if_a.master));
    pixel_stream_source #(.WIDTH(4), .HEIGHT(3), .PIX_W(12), .ADDR_W(19),
                          .H_BLANK(0), .RD_LAT(1))
        u_dut_b (.iCLK(clk), .iRST(rst_n), .bus(if_b.master));
    pixel_stream_source #(.WIDTH(4), .HEIGHT(1), .PIX_W(12), .ADDR_W(19),
                          .H_BLANK(2), .RD_LAT(3))
        u_dut_c (.iCLK(clk), .iRST(rst_n), .bus(if_c.master));

    // Frame memories: mem[a] = a + 100 with the matching read latency
    logic [11:0] mem_a_q, mem_b_q, mem_c1_q, mem_c2_q, mem_c3_q;

    always @(posedge clk) if (if_a.oRD_EN) mem_a_q <= 12'(if_a.oRD_ADDR + 19'd100);
    always @(posedge clk) if (if_b.oRD_EN) mem_b_q <= 12'(if_b.oRD_ADDR + 19'd100);
    always @(posedge clk) begin
        if (if_c.oRD_EN) mem_c1_q <= 12'(if_c.oRD_ADDR + 19'd100);
        mem_c2_q <= mem_c1_q;
        mem_c3_q <= mem_c2_q;
    end

    assign if_a.iSTART   = start & (sel == 0);
    assign if_b.iSTART   = start & (sel == 1);
    assign if_c.iSTART   = start & (sel == 2);
    assign if_a.iPATTERN = pattern;
    assign if_b.iPATTERN = 1'b0;
    assign if_c.iPATTERN = 1'b0;
    assign if_a.iRD_DATA = mem_a_q;
    assign if_b.iRD_DATA = mem_b_q;
    assign if_c.iRD_DATA = mem_c3_q;

    logic        s_rd_en, s_dval, s_sof, s_eol, s_eof, s_busy;
    logic [18:0] s_addr;
    logic [11:0] s_pix;

    always_comb begin
        s_rd_en = if_a.oRD_EN; s_addr = if_a.oRD_ADDR; s_pix = if_a.oPIXEL;
        s_dval  = if_a.oDVAL;  s_sof  = if_a.oSOF;     s_eol = if_a.oEOL;
        s_eof   = if_a.oEOF;   s_busy = if_a.oBUSY;
        case (sel)
            1: begin
                s_rd_en = if_b.oRD_EN; s_addr = if_b.oRD_ADDR; s_pix = if_b.oPIXEL;
                s_dval  = if_b.oDVAL;  s_sof  = if_b.oSOF;     s_eol = if_b.oEOL;
                s_eof   = if_b.oEOF;   s_busy = if_b.oBUSY;
            end
            2: begin
                s_rd_en = if_c.oRD_EN; s_addr = if_c.oRD_ADDR; s_pix = if_c.oPIXEL;
                s_dval  = if_c.oDVAL;  s_sof  = if_c.oSOF;     s_eol = if_c.oEOL;
                s_eof   = if_c.oEOF;   s_busy = if_c.oBUSY;
            end
            default: ;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] m(input int lo, input int hi);
        logic [63:0] r;
        r = '0;
        for (int i = lo; i <= hi; i++) r[i] = 1'b1;
        return r;
    endfunction

    task automatic load_seq(input int n);
        for (int i = 0; i < n; i++) begin
            exp_addr.push_back(i);
            exp_pix.push_back(100 + i);
        end
    endtask

    // Cycle k is the span after the k-th rising edge; sample, then drive.
    task automatic run_cycles(input int ncyc, input logic [63:0] st,
                              input logic [63:0] e_rd, input logic [63:0] e_dv,
                              input logic [63:0] e_sof, input logic [63:0] e_eol,
                              input logic [63:0] e_eof, input logic [63:0] e_busy,
                              input bit chk_addr);
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            check($sformatf("s%0d rd_en@%0d", sel, k), 32'(s_rd_en), 32'(e_rd[k]));
            check($sformatf("s%0d dval@%0d",  sel, k), 32'(s_dval),  32'(e_dv[k]));
            check($sformatf("s%0d sof@%0d",   sel, k), 32'(s_sof),   32'(e_sof[k]));
            check($sformatf("s%0d eol@%0d",   sel, k), 32'(s_eol),   32'(e_eol[k]));
            check($sformatf("s%0d eof@%0d",   sel, k), 32'(s_eof),   32'(e_eof[k]));
            check($sformatf("s%0d busy@%0d",  sel, k), 32'(s_busy),  32'(e_busy[k]));
            if (e_rd[k] && chk_addr && exp_addr.size() > 0)
                check($sformatf("s%0d addr@%0d", sel, k), 32'(s_addr), 32'(exp_addr.pop_front()));
            if (e_dv[k] && exp_pix.size() > 0)
                check($sformatf("s%0d pixel@%0d", sel, k), 32'(s_pix), 32'(exp_pix.pop_front()));
            start = st[k];
        end
        start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " rd_en"}, 32'(s_rd_en), 32'd0);
        check({tag, " addr"},  32'(s_addr),  32'd0);
        check({tag, " pixel"}, 32'(s_pix),   32'd0);
        check({tag, " dval"},  32'(s_dval),  32'd0);
        check({tag, " sof"},   32'(s_sof),   32'd0);
        check({tag, " eol"},   32'(s_eol),   32'd0);
        check({tag, " eof"},   32'(s_eof),   32'd0);
        check({tag, " busy"},  32'(s_busy),  32'd0);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (s_busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(s_busy), 32'd0);
    endtask

    logic [63:0] a_rd, a_dv, a_sof, a_eol, a_eof, a_busy;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        pattern  = 1'b0;
        sel      = 0;

        a_rd   = m(1, 4) | m(7, 10) | m(13, 16);
        a_dv   = m(3, 6) | m(9, 12) | m(15, 18);
        a_sof  = m(3, 3);
        a_eol  = m(6, 6) | m(12, 12) | m(18, 18);
        a_eof  = m(18, 18);
        a_busy = m(1, 18);

        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check_all_zero($sformatf("reset s%0d", s));
        end
        sel = 0;
        @(negedge clk);
        rst_n = 1'b1;

        // Basic frame
        exp_addr.delete(); exp_pix.delete();
        load_seq(12);
        run_cycles(20, m(0, 0), a_rd, a_dv, a_sof, a_eol, a_eof, a_busy, 1'b1);
        check("basic addr left", 32'(exp_addr.size()), 32'd0);

        // Start while busy, then a legal restart at cycle 20
        exp_addr.delete(); exp_pix.delete();
        load_seq(12);
        for (int i = 0; i < 3; i++) exp_addr.push_back(i);
        exp_pix.push_back(100);
        run_cycles(24, m(0, 0) | m(5, 5) | m(18, 18) | m(20, 20),
                   a_rd | m(21, 23), a_dv | m(23, 23), a_sof | m(23, 23),
                   a_eol, a_eof, a_busy | m(21, 23), 1'b1);
        check("restart addr left", 32'(exp_addr.size()), 32'd0);
        wait_idle("restart drain timeout");

        // Reset mid-frame
        exp_addr.delete(); exp_pix.delete();
        load_seq(5);
        run_cycles(8, m(0, 0), a_rd, a_dv, a_sof, a_eol, a_eof, a_busy, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_addr.delete(); exp_pix.delete();
        run_cycles(6, '0, '0, '0, '0, '0, '0, '0, 1'b1);
        load_seq(12);
        run_cycles(20, m(0, 0), a_rd, a_dv, a_sof, a_eol, a_eof, a_busy, 1'b1);
        check("post-reset addr left", 32'(exp_addr.size()), 32'd0);

        // No blanking
        sel = 1;
        exp_addr.delete(); exp_pix.delete();
        load_seq(12);
        run_cycles(16, m(0, 0), m(1, 12), m(3, 14), m(3, 3),
                   m(6, 6) | m(10, 10) | m(14, 14), m(14, 14), m(1, 14), 1'b1);
        check("noblank addr left", 32'(exp_addr.size()), 32'd0);

        // Read latency 3, single line
        sel = 2;
        exp_addr.delete(); exp_pix.delete();
        load_seq(4);
        run_cycles(10, m(0, 0), m(1, 4), m(5, 8), m(5, 5), m(8, 8), m(8, 8),
                   m(1, 8), 1'b1);
        check("lat3 pix left", 32'(exp_pix.size()), 32'd0);

`ifdef PIXEL_STREAM_SOURCE_PATTERN_EN
        // Pattern mode: pixel = {x[5:0], y[5:0]}
        sel = 0;
        pattern = 1'b1;
        exp_addr.delete(); exp_pix.delete();
        exp_pix = '{12'h000, 12'h040, 12'h080, 12'h0C0,
                    12'h001, 12'h041, 12'h081, 12'h0C1,
                    12'h002, 12'h042, 12'h082, 12'h0C2};
        run_cycles(20, m(0, 0), '0, a_dv, a_sof, a_eol, a_eof, a_busy, 1'b0);
        check("pattern pix left", 32'(exp_pix.size()), 32'd0);
        pattern = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
